// File: rtl/multdiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multdiv_ctrl                                                 |
// | Description : Issue/stall controller between the execute stage and the     |
// |               multdiv unit. Latches one MULT/DIV, pulses its start strobe, |
// |               stalls until the result is ready (or a timeout expires), and |
// |               presents one registered writeback (result or $r30 code).     |
// | Options     : MULTDIV_DIV0_FASTPATH_EN - divide by zero completes from     |
// |               IDLE without starting multdiv.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multdiv_ctrl #(
  parameter int MAX_CYCLES   = 40,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_div,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0]  c_CNT_LAST = 6'(MAX_CYCLES - 1);
  localparam logic [4:0]  c_EXC_RD   = 5'd30;
  localparam logic [31:0] c_MUL_EXC  = 32'(MUL_EXC_CODE);
  localparam logic [31:0] c_DIV_EXC  = 32'(DIV_EXC_CODE);

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ctrl_mult_q, ctrl_mult_d;
  logic        ctrl_div_q, ctrl_div_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        div0_fast;
  logic [31:0] exc_code;

`ifdef MULTDIV_DIV0_FASTPATH_EN
  // A divide by zero is known to fault, so it can skip multdiv entirely.
  assign div0_fast = in_is_div & (in_opB == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  assign exc_code = is_div_q ? c_DIV_EXC : c_MUL_EXC;

  // Next-state and registered-output logic; every _d defaults to hold/idle first.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rd_d        = rd_q;
    is_div_d    = is_div_q;
    cnt_d       = cnt_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d    = in_opA;
          opb_d    = in_opB;
          rd_d     = in_rd;
          is_div_d = in_is_div;
          if (div0_fast) begin
            state_d    = S_DONE;
            wb_valid_d = 1'b1;
            wb_rd_d    = c_EXC_RD;
            wb_data_d  = c_DIV_EXC;
          end else begin
            state_d     = S_START;
            ctrl_mult_d = ~in_is_div;
            ctrl_div_d  = in_is_div;
          end
        end
      end
      S_START: begin
        // RDY here may be left over from the previous operation; ignore it.
        cnt_d   = 6'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (md_resultRDY) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          if (md_exception) begin
            wb_rd_d   = c_EXC_RD;
            wb_data_d = exc_code;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = md_result;
          end
        end else if (cnt_q == c_CNT_LAST) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = c_EXC_RD;
          wb_data_d  = exc_code;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      rd_q        <= 5'd0;
      is_div_q    <= 1'b0;
      cnt_q       <= 6'd0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rd_q        <= rd_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Stall drops in DONE so the instruction retires; forced low during reset.
  assign stall = ~reset & ((state_q == S_IDLE & in_valid) |
                           (state_q == S_START) | (state_q == S_WAIT));

  assign md_opA    = opa_q;
  assign md_opB    = opb_q;
  assign ctrl_MULT = ctrl_mult_q;
  assign ctrl_DIV  = ctrl_div_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Issue/stall controller between the execute stage and the `multdiv` unit. Captures a decoded MULT or DIV instruction and holds its operands stable to `multdiv`. Pulses exactly one of `ctrl_MULT`/`ctrl_DIV` for one cycle, stalls the pipeline until `data_resultRDY`, then presents one registered writeback: either the result to `rd`, or the exception code to `$r30`.

## Interface
- `MAX_CYCLES`, default 40: WAIT-state cycles allowed before a forced timeout completion.
- `MUL_EXC_CODE`, default 4: value written to `$r30` on a multiply exception.
- `DIV_EXC_CODE`, default 5: value written to `$r30` on a divide exception.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: X stage holds a mult/div instruction.
- `in_is_div` in 1: 1 = DIV, 0 = MULT.
- `in_opA`, `in_opB` in 32: source operands.
- `in_rd` in 5: destination register.
- `md_opA`, `md_opB` out 32: operands to `multdiv`, held from latched registers.
- `ctrl_MULT`, `ctrl_DIV` out 1: registered one-cycle start pulses.
- `md_result` in 32: `multdiv` `data_result`.
- `md_exception` in 1: `multdiv` `data_exception`.
- `md_resultRDY` in 1: `multdiv` `data_resultRDY`.
- `stall` out 1: freeze F/D/X.
- `wb_valid` out 1: one-cycle writeback strobe.
- `wb_rd` out 5: writeback register.
- `wb_data` out 32: writeback value.

## Operation
- States: IDLE, START, WAIT, DONE (2-bit register). Latched state: `opA`, `opB`, `rd`, `is_div`, and a 6-bit counter.
- IDLE, `in_valid`=1: latch all inputs, go to START.
- IDLE, `in_valid`=0: remain in IDLE.
- START: `ctrl_MULT` or `ctrl_DIV` (selected by `is_div`) is high for this cycle only. Clear the counter. Go to WAIT.
  - `md_resultRDY` is ignored in START, since it may be stale from a prior operation.
- WAIT, `md_resultRDY`=1:
  - If `md_exception`=0: `wb_rd`=`rd`, `wb_data`=`md_result`.
  - If `md_exception`=1: `wb_rd`=30, `wb_data`=`DIV_EXC_CODE` or `MUL_EXC_CODE` (per `is_div`).
  - Go to DONE.
- WAIT, `md_resultRDY`=0: increment the counter.
  - When the counter reaches `MAX_CYCLES`-1 with still no RDY: force the exception writeback (`$r30`, code per `is_div`) and go to DONE.
- DONE: `wb_valid`=1 for one cycle, `in_valid` is ignored, go to IDLE.
  - The next IDLE cycle sees the following instruction.
- `stall` (combinational) = (IDLE & `in_valid`) | START | WAIT. `stall` is low in DONE so the instruction retires.
- `md_opA`/`md_opB` are driven from the latched registers in every state. They are constant from START through DONE.
- `wb_rd`/`wb_data` hold their values until the next capture.

## Timing
- Reset values:
  - State = IDLE.
  - `ctrl_MULT`, `ctrl_DIV`, `wb_valid` = 0.
  - `wb_rd`, `wb_data`, `md_opA`, `md_opB`, counter = 0.
  - `stall` = 0 while reset is held.
- Cycle sequence, with `in_valid` sampled in cycle 0:
  - Cycle 1: START, with the start pulse.
  - Cycle 2 onward: WAIT.
  - RDY seen in cycle N: DONE and `wb_valid` in cycle N+1.
- Timeout: DONE at cycle 2+`MAX_CYCLES`.
- At most one operation is in flight. The block does not queue.
- `reset` during START, WAIT or DONE: return to IDLE next edge.
  - No `wb_valid` is issued and no pulse is re-issued.
  - `multdiv` restarts on the next start pulse.
- `md_resultRDY` and the timeout in the same WAIT cycle: RDY wins, and the real result is taken.

## Configuration
- `MULTDIV_DIV0_FASTPATH_EN` defined:
  - IDLE with `in_valid` & `in_is_div` & `in_opB`==0 goes directly to DONE.
  - No `ctrl_DIV` pulse is issued.
  - Writeback is `wb_rd`=30, `wb_data`=`DIV_EXC_CODE`.
  - `stall` is high only for the capture cycle, so `wb_valid` is seen in cycle 1.
- Undefined: divide-by-zero takes the normal path and relies on `md_exception`.

## Test plan
- MULT 21×3, rd=7, stub RDY after 33 cycles: one `ctrl_MULT` pulse, then `wb_valid` with `wb_rd`=7, `wb_data`=63. `stall` falls in the DONE cycle.
- DIV 21/3, rd=9: one `ctrl_DIV` pulse, then `wb_rd`=9, `wb_data`=7. Operands are constant on `md_opA`/`md_opB` throughout.
- MULT 65536×65536, stubbed exception: `wb_rd`=30, `wb_data`=4.
- DIV 5/0:
  - Fastpath on: no `ctrl_DIV`, `wb_valid` in cycle 1, `wb_rd`=30, `wb_data`=5.
  - Fastpath off: `ctrl_DIV` pulse, then the same writeback after RDY.
- RDY never asserted, `MAX_CYCLES`=40: DONE at cycle 42 with `wb_rd`=30, `wb_data`=4 (MULT). Then back-to-back `in_valid` starts a new operation in cycle 44.
- `reset` pulsed in WAIT cycle 10: IDLE next edge, `stall`=0, no `wb_valid`. Outputs return to reset values. A stale RDY afterwards is ignored.
